// File: rtl/formula_fsm_pkg.sv
// formula_fsm_pkg: shared state encoding and default parameters for the sum-of-roots controller.
package formula_fsm_pkg;
    localparam int N_ARGS_DEF  = 3;
    localparam int N_ISQRT_DEF = 2;
    localparam int W_DEF       = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/isqrt_batch_sel.sv
// isqrt_batch_sel: picks the next batch of operands for the isqrt units starting at ptr.
// With FORMULA_SKIP_ZERO_EN defined, zero operands are skipped since their root is known.
module isqrt_batch_sel
    import formula_fsm_pkg::*;
#(
    parameter int N_ARGS  = N_ARGS_DEF,
    parameter int N_ISQRT = N_ISQRT_DEF,
    parameter int W       = W_DEF,
    parameter int PW      = $clog2(N_ARGS + 1)
) (
    input  logic [N_ARGS*W-1:0]  args,
    input  logic [PW-1:0]        ptr,
    output logic [N_ISQRT*W-1:0] x,
    output logic [N_ISQRT-1:0]   x_vld,
    output logic [PW-1:0]        ptr_nxt
);
`ifdef FORMULA_SKIP_ZERO_EN
    always_comb begin
        int cnt;
        cnt = 0;
        x = '0;
        x_vld = '0;
        ptr_nxt = PW'(N_ARGS);
        for (int i = 0; i < N_ARGS; i++) begin
            if (i >= int'(ptr) && args[i*W +: W] != '0 && cnt < N_ISQRT) begin
                x[cnt*W +: W] = args[i*W +: W];
                x_vld = (x_vld << 1) | N_ISQRT'(1);
                cnt = cnt + 1;
                ptr_nxt = PW'(i + 1);
            end
        end
        // nothing nonzero left: park ptr at the end so the FSM finishes
        if (cnt == 0) ptr_nxt = PW'(N_ARGS);
    end
`else
    always_comb begin
        x = '0;
        x_vld = '0;
        for (int j = 0; j < N_ISQRT; j++) begin
            if (int'(ptr) + j < N_ARGS) begin
                x_vld[j] = 1'b1;
                x[j*W +: W] = args[(int'(ptr) + j)*W +: W];
            end
        end
        ptr_nxt = (int'(ptr) + N_ISQRT >= N_ARGS) ? PW'(N_ARGS) : PW'(int'(ptr) + N_ISQRT);
    end
`endif
endmodule

// File: rtl/formula_n_isqrt_fsm.sv
// formula_n_isqrt_fsm: res = sum of isqrt(arg[i]), batching operands onto N_ISQRT external units.
// Optional build macro FORMULA_SKIP_ZERO_EN: zero operands are never issued.
module formula_n_isqrt_fsm
    import formula_fsm_pkg::*;
#(
    parameter int N_ARGS  = N_ARGS_DEF,
    parameter int N_ISQRT = N_ISQRT_DEF,
    parameter int W       = W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arg_vld,
    output logic                   arg_rdy,
    input  logic [N_ARGS*W-1:0]    args,
    output logic                   res_vld,
    output logic [W-1:0]           res,
    output logic [N_ISQRT-1:0]     isqrt_x_vld,
    output logic [N_ISQRT*W-1:0]   isqrt_x,
    input  logic [N_ISQRT-1:0]     isqrt_y_vld,
    input  logic [N_ISQRT*W/2-1:0] isqrt_y
);
    localparam int PW = $clog2(N_ARGS + 1);
    localparam int H  = W / 2;

    state_t               state_q, state_d;
    logic [N_ARGS*W-1:0]  args_q, args_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [N_ISQRT-1:0]   pending_q, pending_d;
    logic [W-1:0]         res_q, res_d;
    logic                 res_vld_q, res_vld_d;
    logic [N_ISQRT-1:0]   sel_vld;
    logic [PW-1:0]        sel_ptr;
    logic [W-1:0]         acc;

    isqrt_batch_sel #(.N_ARGS(N_ARGS), .N_ISQRT(N_ISQRT), .W(W), .PW(PW)) u_sel (
        .args    (args_q),
        .ptr     (ptr_q),
        .x       (isqrt_x),
        .x_vld   (sel_vld),
        .ptr_nxt (sel_ptr)
    );

    assign arg_rdy     = state_q == IDLE;
    assign isqrt_x_vld = (state_q == ISSUE) ? sel_vld : '0;
    assign res         = res_q;
    assign res_vld     = res_vld_q;

    always_comb begin
        acc = res_q;
        for (int j = 0; j < N_ISQRT; j++)
            acc = acc + ((isqrt_y_vld[j] && pending_q[j]) ? W'(isqrt_y[j*H +: H]) : '0);
        state_d   = state_q;
        args_d    = args_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        case (state_q)
            IDLE: if (arg_vld) begin
                args_d  = args;
                ptr_d   = '0;
                res_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                pending_d = sel_vld;
                ptr_d     = sel_ptr;
                state_d   = (|sel_vld) ? WAIT : IDLE;
                res_vld_d = ~|sel_vld;
            end
            WAIT: begin
                res_d     = acc;
                pending_d = pending_q & ~isqrt_y_vld;
                if (pending_d == '0) begin
                    state_d   = (ptr_q < PW'(N_ARGS)) ? ISSUE : IDLE;
                    res_vld_d = ptr_q >= PW'(N_ARGS);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            args_q    <= '0;
            ptr_q     <= '0;
            pending_q <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            args_q    <= args_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
        end
    end
endmodule

// File: tb/tb_formula_n_isqrt_fsm.sv
// tb_formula_n_isqrt_fsm: transaction-level model of the sum-of-roots controller with emulated isqrt units.
// Expected issue order, batch timing, result cycle and sum are derived from the request alone.
module tb_formula_n_isqrt_fsm;
    localparam int N_ARGS  = 3;
    localparam int N_ISQRT = 2;
    localparam int W       = 32;
    localparam int H       = W / 2;
    localparam int BIG     = 1 << 30;

    logic                   clk, rst, arg_vld, arg_rdy, res_vld;
    logic [N_ARGS*W-1:0]    args;
    logic [W-1:0]           res;
    logic [N_ISQRT-1:0]     isqrt_x_vld, isqrt_y_vld;
    logic [N_ISQRT*W-1:0]   isqrt_x;
    logic [N_ISQRT*H-1:0]   isqrt_y;

    formula_n_isqrt_fsm #(.N_ARGS(N_ARGS), .N_ISQRT(N_ISQRT), .W(W)) dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .args(args),
        .res_vld(res_vld), .res(res), .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
        .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_pass, cyc;
    bit busy, req_pend;
    int exp_q[$];
    logic [W-1:0] ea[N_ARGS];
    logic [W-1:0] exp_sum, last_rv_res;
    int exp_rv_at, exp_iss_at, clr_at, last_idx, last_acc_cyc, last_rv_cyc;
    bit [N_ISQRT-1:0] outst;
    int cnt[N_ISQRT];
    logic [H-1:0] root[N_ISQRT];
    int lat_set[N_ISQRT];
    logic [N_ARGS*W-1:0] req_args;
    int iss_cyc[$];
    logic [N_ISQRT-1:0] iss_mask[$];

    function automatic logic [H-1:0] isq(input logic [W-1:0] v);
        logic [H-1:0] r, t;
        r = '0;
        for (int b = H - 1; b >= 0; b--) begin
            t = r | (H'(1) << b);
            if (64'(t) * 64'(t) <= 64'(v)) r = t;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_arg();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 999));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    endtask

    task automatic model_reset();
        busy = 0;
        req_pend = 0;
        exp_q.delete();
        outst = '0;
        exp_rv_at = BIG;
        exp_iss_at = BIG;
        clr_at = BIG;
        last_idx = -1;
    endtask

    // one clock: check DUT against the model, emulate the units, drive the next inputs
    task automatic step();
        logic [N_ISQRT-1:0] emask;
        bit got;
        int n, idx;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == exp_rv_at) busy = 0;
        chk("arg_rdy", 64'(arg_rdy), 64'(!busy));
        chk("res_vld", 64'(res_vld), 64'(cyc == exp_rv_at));
        if (cyc == exp_rv_at) begin
            chk("res", 64'(res), 64'(exp_sum));
            last_rv_cyc = cyc;
            last_rv_res = res;
            exp_rv_at = BIG;
        end
        if (cyc == clr_at) chk("res_clear", 64'(res), 64'd0);
        n = (exp_q.size() < N_ISQRT) ? exp_q.size() : N_ISQRT;
        emask = (cyc == exp_iss_at) ? N_ISQRT'((1 << n) - 1) : '0;
        chk("x_vld", 64'(isqrt_x_vld), 64'(emask));
        if (isqrt_x_vld != '0) begin
            iss_cyc.push_back(cyc);
            iss_mask.push_back(isqrt_x_vld);
        end
        got = 0;
        isqrt_y_vld = '0;
        for (int j = 0; j < N_ISQRT; j++) isqrt_y[j*H +: H] = H'($urandom);
        for (int j = 0; j < N_ISQRT; j++) begin
            if (outst[j]) begin
                cnt[j]--;
                if (cnt[j] == 0) begin
                    isqrt_y_vld[j] = 1'b1;
                    isqrt_y[j*H +: H] = root[j];
                    outst[j] = 0;
                    got = 1;
                end
            end
        end
        if (got && outst == '0 && busy) begin
            if (exp_q.size() > 0) exp_iss_at = cyc + 1;
            else exp_rv_at = cyc + ((last_idx + 1 < N_ARGS) ? 2 : 1);
        end
        for (int j = 0; j < N_ISQRT; j++) begin
            if (emask[j]) begin
                idx = exp_q.pop_front();
                chk("x_data", 64'(isqrt_x[j*W +: W]), 64'(ea[idx]));
                last_idx = idx;
                outst[j] = 1;
                cnt[j] = (lat_set[j] > 0) ? lat_set[j] : int'($urandom_range(1, 5));
                root[j] = isq(ea[idx]);
            end
        end
        for (int j = 0; j < N_ISQRT; j++)
            if (!isqrt_y_vld[j] && !outst[j] && $urandom_range(0, 3) == 0) isqrt_y_vld[j] = 1'b1;
        arg_vld = 1'b0;
        for (int i = 0; i < N_ARGS; i++) args[i*W +: W] = W'($urandom);
        if (req_pend && !busy) begin
            arg_vld = 1'b1;
            args = req_args;
            req_pend = 0;
            busy = 1;
            last_acc_cyc = cyc;
            clr_at = cyc + 1;
            exp_sum = '0;
            last_idx = -1;
            exp_q.delete();
            for (int i = 0; i < N_ARGS; i++) begin
                ea[i] = req_args[i*W +: W];
                exp_sum = exp_sum + W'(isq(ea[i]));
`ifdef FORMULA_SKIP_ZERO_EN
                if (ea[i] != '0) exp_q.push_back(i);
`else
                exp_q.push_back(i);
`endif
            end
            exp_iss_at = (exp_q.size() > 0) ? cyc + 1 : BIG;
            exp_rv_at = (exp_q.size() > 0) ? BIG : cyc + 2;
        end
        if (busy && cyc - last_acc_cyc > 400) begin
            $display("FAIL watchdog: request accepted at cycle %0d never completed", last_acc_cyc);
            $display("%0d/%0d checks passed", n_pass, n_chk + 1);
            $fatal(1, "watchdog");
        end
    endtask

    task automatic wait_rv(input int after, output int rv, output logic [W-1:0] r);
        for (int s = 0; s < 300 && last_rv_cyc <= after; s++) step();
        if (last_rv_cyc <= after) begin
            n_chk++;
            $display("FAIL rv_timeout: got no res_vld after cycle %0d, required one", after);
        end
        rv = last_rv_cyc;
        r = last_rv_res;
    endtask

    task automatic do_req(input logic [W-1:0] a0, a1, a2, output int t, output int rv, output logic [W-1:0] r);
        iss_cyc.delete();
        iss_mask.delete();
        req_args = {a2, a1, a0};
        req_pend = 1;
        for (int s = 0; s < 400 && req_pend; s++) step();
        t = last_acc_cyc;
        wait_rv(t, rv, r);
    endtask

    int t, rv;
    logic [W-1:0] r;

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        last_acc_cyc = 0; last_rv_cyc = -1;
        rst = 1'b0; arg_vld = 1'b0; args = '0; isqrt_y_vld = '0; isqrt_y = '0;
        for (int j = 0; j < N_ISQRT; j++) lat_set[j] = 0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_arg_rdy", 64'(arg_rdy), 64'd1);
        chk("rst_res_vld", 64'(res_vld), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_x_vld", 64'(isqrt_x_vld), 64'd0);
        chk("isq_max", 64'(isq('1)), 64'd65535);
        chk("isq_99", 64'(isq(32'd99)), 64'd9);
        step(); step();
        rst = 1'b0;
        repeat (2) step();

        lat_set = '{2, 2};
        do_req(32'd16, 32'd81, 32'd100, t, rv, r);
        chk("t1_rv_cycle", 64'(rv - t), 64'd7);
        chk("t1_res", 64'(r), 64'd23);
        chk("t1_batches", 64'(iss_cyc.size()), 64'd2);
        if (iss_cyc.size() == 2) begin
            chk("t1_b0_cycle", 64'(iss_cyc[0] - t), 64'd1);
            chk("t1_b0_mask", 64'(iss_mask[0]), 64'b11);
            chk("t1_b1_cycle", 64'(iss_cyc[1] - t), 64'd4);
            chk("t1_b1_mask", 64'(iss_mask[1]), 64'b01);
        end

        lat_set = '{1, 5};
        do_req(32'd16, 32'd81, 32'd100, t, rv, r);
        chk("t2_rv_cycle", 64'(rv - t), 64'd9);
        chk("t2_res", 64'(r), 64'd23);
        chk("t2_b1_cycle", 64'(iss_cyc.size() == 2 ? iss_cyc[1] - t : -1), 64'd7);

        lat_set = '{1, 1};
        do_req('1, '1, '1, t, rv, r);
        chk("t3_res_max", 64'(r), 64'd196605);
        chk("t3_rv_cycle", 64'(rv - t), 64'd5);

        do_req('0, '0, '0, t, rv, r);
        chk("t4_res_zero", 64'(r), 64'd0);
`ifdef FORMULA_SKIP_ZERO_EN
        chk("t4_no_issue", 64'(iss_cyc.size()), 64'd0);
        chk("t4_rv_cycle", 64'(rv - t), 64'd2);
`else
        chk("t4_rv_cycle", 64'(rv - t), 64'd5);
`endif

        do_req('0, 32'd25, '0, t, rv, r);
        chk("t5_res", 64'(r), 64'd5);
`ifdef FORMULA_SKIP_ZERO_EN
        chk("t5_one_issue", 64'(iss_cyc.size()), 64'd1);
        chk("t5_rv_cycle", 64'(rv - t), 64'd4);
`else
        chk("t5_rv_cycle", 64'(rv - t), 64'd5);
`endif

        req_args = {32'd100, 32'd81, 32'd16};
        req_pend = 1;
        for (int s = 0; s < 400 && req_pend; s++) step();
        t = last_acc_cyc;
        req_args = {32'd9, 32'd4, 32'd1};
        req_pend = 1;
        wait_rv(t, rv, r);
        chk("b2b_first_res", 64'(r), 64'd23);
        chk("b2b_accept_in_rv", 64'(last_acc_cyc), 64'(rv));
        wait_rv(rv, rv, r);
        chk("b2b_second_res", 64'(r), 64'd6);

        lat_set = '{4, 4};
        req_args = {32'd100, 32'd81, 32'd16};
        req_pend = 1;
        for (int s = 0; s < 400 && req_pend; s++) step();
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_x_vld", 64'(isqrt_x_vld), 64'd0);
        chk("mid_rst_arg_rdy", 64'(arg_rdy), 64'd1);
        chk("mid_rst_res_vld", 64'(res_vld), 64'd0);
        chk("mid_rst_res", 64'(res), 64'd0);
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        repeat (6) step();
        lat_set = '{0, 0};
        do_req(32'd1, 32'd4, 32'd9, t, rv, r);
        chk("post_rst_res", 64'(r), 64'd6);

        for (int k = 0; k < 150; k++) begin
            for (int j = 0; j < N_ISQRT; j++)
                lat_set[j] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            for (int i = 0; i < N_ARGS; i++) req_args[i*W +: W] = rnd_arg();
            req_pend = 1;
            for (int s = 0; s < 400 && req_pend; s++) step();
            repeat ($urandom_range(0, 2)) step();
        end
        for (int s = 0; s < 300 && busy; s++) step();
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
